// File: rtl/simon_player.sv
// simon_player: watches the memory game's LED flashes, records the colour sequence
// and replays it on the keys until the game shows win or loss.
module simon_player #(
  parameter int SIZE_ADDRESS = 5,
  parameter int KEY_DELAY = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    go_i,
  input  logic                    miss_en_i,
  input  logic [SIZE_ADDRESS-1:0] miss_round_i,
  input  logic [3:0]              nl_i,
  input  logic                    nloss_i,
  output logic                    start_o,
  output logic [3:0]              k_o,
  output logic                    busy_o,
  output logic                    won_o,
  output logic                    lost_o,
  output logic [SIZE_ADDRESS-1:0] round_o,
  output logic                    proto_err_o
);
  localparam logic [SIZE_ADDRESS-1:0] LAST = '1;
  localparam logic [3:0] DELAY = 4'(KEY_DELAY);
  typedef enum logic [3:0] {IDLE, START, WATCH, SHOW, PRESS_WAIT, PRESS, ECHO, WON, LOST} state_t;
  state_t state_q, state_d;
  logic [1:0] mem_q [2**SIZE_ADDRESS];
  logic [SIZE_ADDRESS-1:0] idx_q, idx_d, round_q, round_d, miss_round_q, miss_round_d;
  logic [3:0] cnt_q, cnt_d, k_q, k_d;
  logic start_q, start_d, won_q, won_d, lost_q, lost_d, perr_q, perr_d, miss_en_q, miss_en_d;
  logic one_hot, mem_we, last_elem;
  logic [1:0] colour, key_c;
  assign one_hot = nl_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign colour = {nl_i[3] | nl_i[2], nl_i[3] | nl_i[1]};
  assign last_elem = idx_q == round_q;
  // the deliberate miss shifts the first key of the chosen round by one colour
  assign key_c = mem_q[idx_q] + 2'(miss_en_q && round_q == miss_round_q && idx_q == '0);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    round_d = round_q;
    cnt_d = cnt_q;
    k_d = k_q;
    start_d = 1'b0;
    won_d = won_q;
    lost_d = lost_q;
    perr_d = perr_q;
    miss_en_d = miss_en_q;
    miss_round_d = miss_round_q;
    mem_we = 1'b0;
    if (busy_o && nloss_i) begin
      state_d = LOST;
      k_d = '0;
      lost_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, WON, LOST: if (go_i) begin
          miss_en_d = miss_en_i;
          miss_round_d = miss_round_i;
          won_d = 1'b0;
          lost_d = 1'b0;
          perr_d = 1'b0;
          round_d = '0;
          idx_d = '0;
          start_d = 1'b1;
          state_d = START;
        end
        START: state_d = WATCH;
        WATCH: if (nl_i == 4'b1111) begin
          state_d = WON;
          won_d = 1'b1;
        end else if (one_hot) begin
          mem_we = 1'b1;
          state_d = SHOW;
          perr_d = perr_q | (idx_q < round_q && mem_q[idx_q] != colour);
        end else if (nl_i != '0) perr_d = 1'b1;
        SHOW: if (nl_i == '0) begin
          state_d = last_elem ? PRESS_WAIT : WATCH;
          idx_d = last_elem ? '0 : idx_q + 1'b1;
          cnt_d = DELAY;
        end
        PRESS_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          k_d = 4'b0001 << key_c;
          state_d = PRESS;
        end
        PRESS: if (nl_i != '0) begin
          k_d = '0;
          state_d = ECHO;
        end
        ECHO: if (nl_i == '0) begin
          state_d = last_elem ? WATCH : PRESS_WAIT;
          idx_d = last_elem ? '0 : idx_q + 1'b1;
          round_d = last_elem && round_q != LAST ? round_q + 1'b1 : round_q;
          cnt_d = DELAY;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      round_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      start_q <= 1'b0;
      won_q <= 1'b0;
      lost_q <= 1'b0;
      perr_q <= 1'b0;
      miss_en_q <= 1'b0;
      miss_round_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      round_q <= round_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      start_q <= start_d;
      won_q <= won_d;
      lost_q <= lost_d;
      perr_q <= perr_d;
      miss_en_q <= miss_en_d;
      miss_round_q <= miss_round_d;
    end
  end
  always_ff @(posedge clock_i) if (mem_we) mem_q[idx_q] <= colour;
  assign busy_o = !(state_q inside {IDLE, WON, LOST});
  assign start_o = start_q;
  assign k_o = k_q;
  assign won_o = won_q;
  assign lost_o = lost_q;
  assign round_o = round_q;
  assign proto_err_o = perr_q;
endmodule

// File: tb/tb_simon_player.sv
// tb_simon_player: closed-loop game model with a key scoreboard, plus corner sequences.
module tb_simon_player;
  logic clock = 0, reset = 1, go = 0, miss_en = 0, nloss = 0;
  logic [4:0] miss_round = '0;
  logic [3:0] nl = '0;
  logic start_o, busy_o, won_o, lost_o, proto_err_o;
  logic [3:0] k_o;
  logic [4:0] round_o;
  int tests = 0, fails = 0;
  logic [3:0] sb [$];

  simon_player #(.SIZE_ADDRESS(5), .KEY_DELAY(2)) dut (
    .clock_i(clock), .reset_i(reset), .go_i(go), .miss_en_i(miss_en), .miss_round_i(miss_round),
    .nl_i(nl), .nloss_i(nloss), .start_o(start_o), .k_o(k_o), .busy_o(busy_o), .won_o(won_o),
    .lost_o(lost_o), .round_o(round_o), .proto_err_o(proto_err_o));

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flash(input logic [1:0] c);
    nl = 4'b0001 << c;
    tick;
    tick;
    nl = '0;
    tick;
    tick;
  endtask

  task automatic press(output logic ok);
    int w = 0;
    while (k_o == '0 && w < 64) begin
      tick;
      w++;
    end
    ok = k_o != '0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL key_timeout actual=0 required=key");
    end else if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL key_unexpected actual=%0h required=none", k_o);
    end else chk("key", k_o, sb.pop_front());
  endtask

  task automatic echo;
    nl = k_o;
    tick;
    chk("k_drop", k_o, 0);
    tick;
    nl = '0;
    tick;
  endtask

  task automatic run_game(input logic men, input logic [4:0] mr, output logic was_lost);
    logic [1:0] seq [32];
    logic ok;
    was_lost = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) seq[i] = 2'($urandom_range(3));
    go = 1;
    miss_en = men;
    miss_round = mr;
    tick;
    go = 0;
    miss_en = 0;
    miss_round = '0;
    chk("start_hi", start_o, 1);
    chk("go_clears_won", won_o, 0);
    chk("go_clears_lost", lost_o, 0);
    tick;
    chk("start_lo", start_o, 0);
    for (int r = 0; r < 32; r++) begin
      tick;
      tick;
      for (int i = 0; i <= r; i++) begin
        sb.push_back(men && 5'(r) == mr && i == 0 ? 4'b0001 << 2'(seq[0] + 2'd1) : 4'b0001 << seq[i]);
        flash(seq[i]);
      end
      for (int i = 0; i <= r; i++) begin
        press(ok);
        if (!ok) return;
        if (k_o != 4'b0001 << seq[i]) begin
          nloss = 1;
          tick;
          chk("lost_after_nloss", lost_o, 1);
          chk("k_after_loss", k_o, 0);
          chk("loss_round", round_o, r);
          nloss = 0;
          tick;
          chk("k_stays_0", k_o, 0);
          was_lost = 1'b1;
          return;
        end
        echo;
      end
    end
    tick;
    tick;
    nl = 4'b1111;
    tick;
    nl = '0;
    tick;
  endtask

  typedef struct {
    logic       men;
    logic [4:0] mr;
    logic       exp_lost;
    logic [4:0] exp_round;
  } vec_t;
  vec_t vecs [4];

  initial begin
    logic lost_seen, ok;
    vecs[0] = '{1'b0, 5'd0, 1'b0, 5'd31};
    vecs[1] = '{1'b1, 5'd0, 1'b1, 5'd0};
    vecs[2] = '{1'b1, 5'd3, 1'b1, 5'd3};
    vecs[3] = '{1'b1, 5'd31, 1'b1, 5'd31};
    tick;
    tick;
    reset = 0;
    chk("rst_start", start_o, 0);
    chk("rst_k", k_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_won", won_o, 0);
    chk("rst_lost", lost_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_perr", proto_err_o, 0);
    for (int v = 0; v < 4; v++) begin
      run_game(vecs[v].men, vecs[v].mr, lost_seen);
      chk("outcome_lost", lost_seen, vecs[v].exp_lost);
      chk("final_lost", lost_o, vecs[v].exp_lost);
      chk("final_won", won_o, !vecs[v].exp_lost);
      chk("final_round", round_o, vecs[v].exp_round);
      chk("final_perr", proto_err_o, 0);
      chk("final_k", k_o, 0);
      chk("final_busy", busy_o, 0);
    end
    // illegal LED pattern while watching
    reset = 1;
    tick;
    reset = 0;
    sb.delete();
    go = 1;
    tick;
    go = 0;
    tick;
    go = 1;
    tick;
    go = 0;
    chk("go_ignored_busy", start_o, 0);
    nl = 4'b0101;
    tick;
    chk("perr_set", proto_err_o, 1);
    chk("perr_no_key", k_o, 0);
    nl = '0;
    tick;
    tick;
    chk("perr_sticky", proto_err_o, 1);
    chk("perr_busy", busy_o, 1);
    sb.push_back(4'b0001);
    flash(2'd0);
    press(ok);
    if (ok) echo;
    chk("round_after_r0", round_o, 1);
    // replay mismatch, then reset while pressing
    reset = 1;
    tick;
    reset = 0;
    sb.delete();
    go = 1;
    tick;
    go = 0;
    tick;
    sb.push_back(4'b0010);
    flash(2'd1);
    press(ok);
    if (ok) echo;
    tick;
    tick;
    chk("no_perr_yet", proto_err_o, 0);
    sb.push_back(4'b0100);
    flash(2'd2);
    chk("mismatch_perr", proto_err_o, 1);
    sb.push_back(4'b0001);
    flash(2'd0);
    press(ok);
    chk("mid_busy", busy_o, 1);
    reset = 1;
    tick;
    reset = 0;
    chk("rst_mid_k", k_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_round", round_o, 0);
    chk("rst_mid_perr", proto_err_o, 0);
    sb.delete();
    // restart from WON
    go = 1;
    tick;
    go = 0;
    tick;
    nl = 4'b1111;
    tick;
    nl = '0;
    chk("won_direct", won_o, 1);
    chk("won_not_busy", busy_o, 0);
    go = 1;
    tick;
    go = 0;
    chk("won_cleared", won_o, 0);
    chk("restart_start", start_o, 1);
    chk("restart_busy", busy_o, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
